// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and command-master FSM encoding
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding APB3 master driven by a valid/ready command stream
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  apb_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             expire;

  // PREADY is checked before expiry everywhere, so a late PREADY still completes normally
  assign expire = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LIMIT);

  // Control outputs decode the async-reset state so they drop the moment reset asserts
  assign cmd_ready = (state == ST_IDLE);
  assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE   = (state == ST_ACCESS);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (cmd_valid) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (PREADY || expire) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end

      if (state == ST_SETUP)
        wait_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY && wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + CNT_W'(1);

      if (state == ST_ACCESS) begin
        if (PREADY) begin
          rsp_rdata   <= PWRITE ? '0 : PRDATA;
          rsp_err     <= PSLVERR;
          rsp_timeout <= 1'b0;
        end else if (expire) begin
          rsp_rdata   <= '0;
          rsp_err     <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - randomized self-checking bench for apb_cmd_master
module tb_apb_cmd_master;

  localparam int T = 8;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  apb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One command end to end; w = ACCESS cycles with PREADY low before it rises, hold = rsp_ready stall
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic serr, input logic [31:0] rdata, input int hold);
    int          acc;
    logic [31:0] exp_rdata;
    logic        exp_err, exp_to;
    if (w <= T) begin
      acc = w + 1;
      exp_rdata = wr ? 32'h0 : rdata;
      exp_err = serr;
      exp_to = 1'b0;
    end else begin
      acc = T + 1;
      exp_rdata = 32'h0;
      exp_err = 1'b1;
      exp_to = 1'b1;
    end

    check_eq("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; rsp_ready = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;

    for (int k = 1; k <= 1 + acc; k++) begin
      if (k == 1) begin
        check_eq("setup_phase", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b1000);
      end else begin
        check_eq("access_phase", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b1100);
        check_eq("paddr", PADDR, addr);
        check_eq("pwrite", PWRITE, wr);
        check_eq("pwdata", PWDATA, wdata);
        PREADY  = ((k - 2) == w);
        PSLVERR = PREADY ? serr : 1'($urandom);
        PRDATA  = PREADY ? rdata : $urandom;
      end
      @(negedge PCLK);
    end
    PREADY = 1'b0; PSLVERR = 1'b0;

    for (int i = 0; i <= hold; i++) begin
      check_eq("resp_phase", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0010);
      check_eq("rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("rsp_err", rsp_err, exp_err);
      check_eq("rsp_timeout", rsp_timeout, exp_to);
      if (i < hold) begin
        cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      end else begin
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
      end
      @(negedge PCLK);
    end
    rsp_ready = 1'b0;
    check_eq("post_idle", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    check_eq("paddr_held", PADDR, addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    check_eq("rst_ctrl", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, cmd_ready}, 7'b0000001);
    check_eq("rst_paddr", PADDR, 0);
    check_eq("rst_pwdata", PWDATA, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // write then status read
    run_txn(1'b1, 32'h0, 32'h41, 0, 1'b0, 32'hdead_beef, 0);
    run_txn(1'b0, 32'h4, 32'h0, 0, 1'b0, 32'h3, 0);
    // wait states, timeout, race at expiry, slave error, backpressure
    run_txn(1'b1, 32'h10, 32'h1234_5678, 5, 1'b0, 32'h0, 0);
    run_txn(1'b0, 32'h20, 32'h0, 50, 1'b0, 32'h5555_aaaa, 1);
    run_txn(1'b0, 32'h24, 32'h0, T, 1'b0, 32'hcafe_f00d, 0);
    run_txn(1'b0, 32'h8, 32'h0, 0, 1'b1, 32'h7, 0);
    run_txn(1'b1, 32'h3, 32'h99, 2, 1'b0, 32'h0, 10);

    // reset asserted in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h77;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check_eq("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check_eq("rst_async_drop", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_eq("rst_recover", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
    check_eq("rst_paddr_clr", PADDR, 0);
    run_txn(1'b0, 32'h44, 32'h0, 1, 1'b0, 32'h0bad_cafe, 0);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, T + 3)),
              1'($urandom), $urandom, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB3 master that turns a valid/ready command stream (e.g. from a host bridge or test sequencer) into APB SETUP/ACCESS transfers. It sits directly upstream of `uart_apb_wrapper`, driving its PSEL/PENABLE/PWRITE/PADDR/PWDATA and consuming PRDATA/PREADY/PSLVERR. It returns each result on a valid/ready response channel and aborts with an error if PREADY never arrives within a bounded number of cycles.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS cycles waiting for PREADY. A value of 0 disables the timeout.
- `PCLK`  in  1  system clock; all logic is on the rising edge.
- `PRESETn`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `cmd_valid`  in  1  a command is offered.
- `cmd_ready`  out  1  the master accepts the command this cycle.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  APB address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  a response is held.
- `rsp_ready`  in  1  the consumer accepts the response.
- `rsp_rdata`  out  32  read data; 0 for writes and for timeouts.
- `rsp_err`  out  1  PSLVERR was sampled high, or a timeout occurred.
- `rsp_timeout`  out  1  the transfer was aborted by the timeout.
- `PSEL`, `PENABLE`, `PWRITE`  out  1 each  APB master controls.
- `PADDR`, `PWDATA`  out  32 each  APB address and write data.
- `PRDATA`  in  32  APB read data.
- `PREADY`, `PSLVERR`  in  1 each  APB completion and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`&&`cmd_ready`: register write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0, `cmd_ready`=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable.
  - On PREADY=1:
    - capture `rsp_rdata` = PRDATA if read, else 0;
    - `rsp_err` = PSLVERR; `rsp_timeout` = 0;
    - go to RESP.
  - Otherwise increment the wait counter.
  - If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES` with PREADY still low: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, go to RESP.
  - If PREADY rises on the same cycle the counter expires, PREADY wins (normal completion).
- **RESP**
  - PSEL=0, PENABLE=0, `rsp_valid`=1. Response fields are held stable until `rsp_ready`.
  - On `rsp_ready`: go to IDLE.
  - No new command is accepted in RESP.
- Wait counter:
  - width is max(1, $clog2(`TIMEOUT_CYCLES`+1));
  - clears on entry to ACCESS;
  - saturates and never wraps.
- PADDR/PWRITE/PWDATA hold their last value outside a transfer. PADDR is passed through as given, with no alignment check.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0. All outputs are 0 except `cmd_ready`=1. This covers `rsp_*`, PSEL, PENABLE, PWRITE, PADDR and PWDATA.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronous). The in-flight command and any pending response are discarded.
- Handshake completes at the clock edge with valid&&ready on both channels.
- Latency with PREADY tied high (as on `uart_apb_wrapper`):
  - accept at edge N;
  - SETUP during N+1;
  - ACCESS during N+2;
  - `rsp_valid` high from edge N+3.
- Each PREADY wait cycle adds one cycle of latency.
- Minimum period with `rsp_ready`=1: 4 cycles per command (IDLE, SETUP, ACCESS, RESP).
- Timeout: `rsp_valid` rises `TIMEOUT_CYCLES`+1 edges after ACCESS entry.

## Structure
- Shared package/header `apb_pkg`:
  - FSM state encoding (2-bit localparams ST_IDLE=0, ST_SETUP=1, ST_ACCESS=2, ST_RESP=3);
  - APB_ADDR_W=32 and APB_DATA_W=32.
- Single flat module. No sub-module is required; the timeout counter is inline.
- Top-level integration instantiates `apb_cmd_master` feeding `uart_apb_wrapper` on the same PCLK/PRESETn.

## Test plan
- **Write then status read:**
  - Write addr 0x0, wdata 0x41, PREADY=1 → PSEL seen N+1..N+2, PENABLE only N+2, PWDATA=0x41, `rsp_valid` at N+3, `rsp_err`=0, `rsp_rdata`=0.
  - Then read addr 0x4 with PRDATA=0x3 → `rsp_rdata`=0x00000003.
- **Wait states:** PREADY low for 5 ACCESS cycles → PADDR/PWRITE/PWDATA stable throughout; `rsp_valid` 5 cycles later than nominal; `rsp_timeout`=0.
- **Timeout:** `TIMEOUT_CYCLES`=8, PREADY held 0 → `rsp_valid` after 9 ACCESS edges; `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0; PSEL low in RESP.
- **Slave error and timeout race:**
  - PSLVERR=1 with PREADY on a read → `rsp_err`=1, `rsp_timeout`=0.
  - PREADY on the expiry cycle → normal completion.
- **Backpressure:** `rsp_ready`=0 for 10 cycles → response fields stable, `cmd_ready`=0 and new `cmd_valid` ignored; accepted 1 cycle after `rsp_ready`.
- **Reset mid-ACCESS:** PRESETn low during ACCESS → PSEL/PENABLE 0 before the next edge; after release state=IDLE, `cmd_ready`=1, `rsp_valid`=0.
